psum_acc_wb: RTL and testbench

Downstream writeback stage for the corelet. It drains column partial-sum vectors from the ofifo and read-modify-writes them into the psum SRAM. When accumulation is enabled, each vector is added lane-wise, with saturation, to the word already stored at the target address. It sequences one run of N consecutive addresses per start pulse, then signals done.

---
 rtl/psum_acc_wb.sv | 131 +++++++++++++
 tb/tb_psum_acc_wb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/psum_acc_wb.sv
`default_nettype none
// ============================================================================
//  Module   : psum_acc_wb
//  Purpose  : Writeback stage of the corelet. Pops column partial-sum vectors
//             from the ofifo and writes them into the psum SRAM. Optionally it
//             accumulates each vector lane-wise, with saturation, onto the
//             word already stored at the target address.
//             One start pulse sequences a run of num_vec consecutive
//             addresses, then pulses done.
//  Ports    : clk, reset (async, active-low)
//             start/base_addr/num_vec/acc_en  - run command, sampled at start
//             ofifo_valid/ofifo_out/ofifo_rd  - ofifo pop interface
//             sram_cen/sram_wen/sram_addr/sram_d/sram_q - psum SRAM port
//             busy/done                       - run status
//  Revision : 1.0  initial release
// ============================================================================
module psum_acc_wb #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ADDR_W  = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [ADDR_W:0]        num_vec,
    input  logic                   acc_en,
    input  logic                   ofifo_valid,
    input  logic [COL*PSUM_BW-1:0] ofifo_out,
    output logic                   ofifo_rd,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [COL*PSUM_BW-1:0] sram_d,
    input  logic [COL*PSUM_BW-1:0] sram_q,
    output logic                   busy,
    output logic                   done
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_req  = 3'd1;
    localparam logic [2:0] c_st_cap  = 3'd2;
    localparam logic [2:0] c_st_wr   = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    localparam logic [ADDR_W:0]    c_one = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [PSUM_BW-1:0] c_max = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0] c_min = {1'b1, {(PSUM_BW-1){1'b0}}};

    logic [2:0]             r_state;
    logic [ADDR_W-1:0]      r_cur_addr;
    logic [ADDR_W:0]        r_remaining;
    logic                   r_acc_q;
    logic [COL*PSUM_BW-1:0] r_sram_d;
    logic [COL*PSUM_BW-1:0] w_sum;
    logic                   w_sram_rd;
    logic                   w_sram_wr;

    // Per-lane add with saturation. When not accumulating the addend is
    // forced to zero, so the sum can never overflow and passes straight through.
    for (genvar i = 0; i < COL; i++) begin : g_lane
        logic [PSUM_BW-1:0] w_a;
        logic [PSUM_BW-1:0] w_b;
        logic [PSUM_BW:0]   w_s;

        assign w_a = ofifo_out[i*PSUM_BW +: PSUM_BW];
        assign w_b = r_acc_q ? sram_q[i*PSUM_BW +: PSUM_BW] : '0;
        assign w_s = {w_a[PSUM_BW-1], w_a} + {w_b[PSUM_BW-1], w_b};
        // The two top bits differ only on overflow; the top bit gives the true sign.
        assign w_sum[i*PSUM_BW +: PSUM_BW] =
            (w_s[PSUM_BW] == w_s[PSUM_BW-1]) ? w_s[PSUM_BW-1:0] :
            (w_s[PSUM_BW] ? c_min : c_max);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_st_idle;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_acc_q     <= 1'b0;
            r_sram_d    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_cur_addr  <= base_addr;
                        r_remaining <= num_vec;
                        r_acc_q     <= acc_en;
                        r_state     <= (num_vec == '0) ? c_st_done : c_st_req;
                    end
                end
                c_st_req: begin
                    if (ofifo_valid) begin
                        r_state <= c_st_cap;
                    end
                end
                c_st_cap: begin
                    r_sram_d <= w_sum;
                    r_state  <= c_st_wr;
                end
                c_st_wr: begin
                    r_cur_addr  <= r_cur_addr + 1'b1;
                    r_remaining <= r_remaining - c_one;
                    r_state     <= (r_remaining == c_one) ? c_st_done : c_st_req;
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // The SRAM read is issued alongside the pop, so both ofifo_out and
    // sram_q land together in CAP. Read (REQ) and write (WR) are never in
    // the same state, which keeps the single-port SRAM conflict-free.
    assign ofifo_rd  = (r_state == c_st_req) && ofifo_valid;
    assign w_sram_rd = ofifo_rd && r_acc_q;
    assign w_sram_wr = (r_state == c_st_wr);
    assign sram_cen  = ~(w_sram_rd | w_sram_wr);
    assign sram_wen  = ~w_sram_wr;
    assign sram_addr = r_cur_addr;
    assign sram_d    = r_sram_d;
    assign busy      = (r_state == c_st_req) || (r_state == c_st_cap) ||
                       (r_state == c_st_wr);
    assign done      = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_psum_acc_wb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psum_acc_wb
//  Purpose  : Directed self-checking bench for psum_acc_wb with a behavioural
//             psum SRAM and ofifo.
//  Revision : 1.0  initial release
// ============================================================================
module tb_psum_acc_wb;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int ADDR_W  = 11;
    localparam int VW      = COL * PSUM_BW;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_vec;
    logic              acc_en;
    logic              ofifo_valid;
    logic [VW-1:0]     ofifo_out;
    logic              ofifo_rd;
    logic              sram_cen;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [VW-1:0]     sram_d;
    logic [VW-1:0]     sram_q;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    psum_acc_wb #(.COL(COL), .PSUM_BW(PSUM_BW), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_vec(num_vec), .acc_en(acc_en), .ofifo_valid(ofifo_valid),
        .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd), .sram_cen(sram_cen),
        .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d),
        .sram_q(sram_q), .busy(busy), .done(done)
    );

    // Behavioural SRAM with a bench-side preload port.
    logic [VW-1:0]     mem [0:2047];
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [VW-1:0]     pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_addr] <= sram_d;
            else           sram_q <= mem[sram_addr];
        end
    end

    // Behavioural ofifo: data appears the cycle after a pop.
    logic [VW-1:0] fq [$];
    always @(posedge clk) begin
        if (ofifo_rd) ofifo_out <= (fq.size() != 0) ? fq.pop_front() : '0;
    end

    // Event counters, only ever read as deltas.
    int rd_cnt = 0, srd_cnt = 0, swr_cnt = 0, done_cnt = 0, cen_cnt = 0;
    always @(posedge clk) begin
        if (ofifo_rd)              rd_cnt   <= rd_cnt + 1;
        if (!sram_cen && sram_wen) srd_cnt  <= srd_cnt + 1;
        if (!sram_cen && !sram_wen) swr_cnt <= swr_cnt + 1;
        if (done)                  done_cnt <= done_cnt + 1;
        if (!sram_cen)             cen_cnt  <= cen_cnt + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [VW-1:0] rep(input logic [PSUM_BW-1:0] v);
        return {COL{v}};
    endfunction

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [VW-1:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Raises start for one edge; returns in the first cycle after start.
    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n, input logic acc);
        base_addr = b; num_vec = n; acc_en = acc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k;
        k = 0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, {127'd0, done}, {127'd0, 1'b1});
        @(negedge clk);
    endtask

    int  b_cnt, done_at, d0, d1, d2, d3, d4;
    logic stall_ok;

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; num_vec = '0; acc_en = 1'b0;
        ofifo_valid = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        #1;
        check("rst_outputs", {ofifo_rd, sram_cen, sram_wen, busy, done}, 5'b01100);
        check("rst_addr", sram_addr, '0);
        check("rst_d", sram_d, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Overwrite, two vectors
        fq.push_back(rep(16'd5));
        fq.push_back(rep(16'hFFF9));
        ofifo_valid = 1'b1;
        d0 = rd_cnt; d1 = srd_cnt; d2 = swr_cnt;
        pulse_start(11'h010, 12'd2, 1'b0);
        b_cnt = 0; done_at = 0;
        for (int i = 1; i <= 15; i++) begin
            if (busy) b_cnt++;
            if (done && done_at == 0) done_at = i;
            @(negedge clk);
        end
        check("ow_done_cycle", done_at, 7);
        check("ow_busy_cycles", b_cnt, 6);
        check("ow_mem0", mem[11'h010], rep(16'd5));
        check("ow_mem1", mem[11'h011], rep(16'hFFF9));
        check("ow_no_read", srd_cnt - d1, 0);
        check("ow_pops", rd_cnt - d0, 2);
        check("ow_writes", swr_cnt - d2, 2);

        // Accumulate with saturation
        preload(11'h020, {80'd0, 16'h8000, 16'd32000, 16'd100});
        fq.push_back({80'd0, 16'hFFFB, 16'd1000, 16'hFFE2});
        d1 = srd_cnt;
        pulse_start(11'h020, 12'd1, 1'b1);
        wait_done("acc_done", 20);
        check("acc_mem", mem[11'h020], {80'd0, 16'h8000, 16'h7FFF, 16'd70});
        check("acc_one_read", srd_cnt - d1, 1);

        // Stall in REQ
        ofifo_valid = 1'b0;
        fq.push_back(rep(16'd3));
        d0 = rd_cnt;
        pulse_start(11'h030, 12'd1, 1'b0);
        stall_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (ofifo_rd !== 1'b0 || sram_cen !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
        end
        check("stall_hold", {127'd0, stall_ok}, {127'd0, 1'b1});
        ofifo_valid = 1'b1;
        #1;
        check("stall_rd_on_valid", {127'd0, ofifo_rd}, {127'd0, 1'b1});
        @(negedge clk);
        wait_done("stall_done", 20);
        check("stall_one_pop", rd_cnt - d0, 1);
        check("stall_mem", mem[11'h030], rep(16'd3));

        // Empty run
        d0 = rd_cnt; d4 = cen_cnt;
        pulse_start(11'h050, 12'd0, 1'b0);
        check("empty_done_next", {busy, done}, 2'b01);
        @(negedge clk);
        check("empty_done_once", {busy, done}, 2'b00);
        check("empty_no_pop", rd_cnt - d0, 0);
        check("empty_no_cen", cen_cnt - d4, 0);

        // Address wrap with an ignored second start
        preload(11'h100, rep(16'd55));
        fq.push_back(rep(16'd11));
        fq.push_back(rep(16'd22));
        d3 = done_cnt;
        pulse_start(11'd2047, 12'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        pulse_start(11'h100, 12'd5, 1'b0);
        for (int i = 0; i < 20; i++) @(negedge clk);
        check("wrap_one_done", done_cnt - d3, 1);
        check("wrap_mem_top", mem[11'd2047], rep(16'd11));
        check("wrap_mem_zero", mem[11'd0], rep(16'd22));
        check("wrap_ignored_start", mem[11'h100], rep(16'd55));
        check("wrap_idle", {127'd0, busy}, '0);

        // Reset during CAP
        preload(11'h040, rep(16'd9));
        fq.push_back(rep(16'd1));
        pulse_start(11'h040, 12'd1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_outputs", {ofifo_rd, sram_cen, sram_wen, busy, done}, 5'b01100);
        check("midrst_addr_d", {sram_addr, sram_d[15:0]}, '0);
        @(negedge clk);
        @(negedge clk);
        check("midrst_mem_kept", mem[11'h040], rep(16'd9));
        reset = 1'b1;
        @(negedge clk);
        fq.push_back(rep(16'd4));
        pulse_start(11'h041, 12'd1, 1'b0);
        wait_done("post_rst_done", 20);
        check("post_rst_mem", mem[11'h041], rep(16'd4));
        check("post_rst_kept", mem[11'h040], rep(16'd9));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
